// File: rtl/regfile_arbiter.sv
// Round-robin two-client access controller for a shared register file.
// One request is served every three cycles: IDLE grant, ACCESS, ACK.

module regfile_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  wr_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  wr_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  rf_w_en,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [ADDR_WIDTH-1:0] rf_r_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    input  logic [DATA_WIDTH-1:0] rf_r_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic                  prio_r, prio_s;
    logic                  win_b_r, win_b_s;
    logic                  wr_r, wr_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic                  w_en_r, w_en_s;
    logic                  ack_a_r, ack_a_s;
    logic                  ack_b_r, ack_b_s;
    logic                  busy_r, busy_s;
    logic                  pick_b_s;

    // Next-state, grant selection and next values of every registered output.
    always_comb begin
        state_s  = state_r;
        prio_s   = prio_r;
        win_b_s  = win_b_r;
        wr_s     = wr_r;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        rdata_s  = rdata_r;
        w_en_s   = 1'b0;
        ack_a_s  = 1'b0;
        ack_b_s  = 1'b0;
        busy_s   = busy_r;
        pick_b_s = req_b && (!req_a || prio_r);
        case (state_r)
            IDLE: begin
                if (req_a || req_b) begin
                    win_b_s = pick_b_s;
                    prio_s  = !pick_b_s;  // point at the loser of this grant
                    wr_s    = pick_b_s ? wr_b : wr_a;
                    addr_s  = pick_b_s ? addr_b : addr_a;
                    if (wr_s) begin
                        wdata_s = pick_b_s ? wdata_b : wdata_a;
                    end else begin
                        wdata_s = wdata_r;
                    end
                    w_en_s  = wr_s;
                    busy_s  = 1'b1;
                    state_s = ACCESS;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (!wr_r) begin
                    rdata_s = rf_r_data;
                end else begin
                    rdata_s = rdata_r;
                end
                ack_a_s = !win_b_r;
                ack_b_s = win_b_r;
                busy_s  = 1'b1;
                state_s = ACK;
            end
            ACK: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            prio_r  <= 1'b0;
            win_b_r <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            rdata_r <= {DATA_WIDTH{1'b0}};
            w_en_r  <= 1'b0;
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            prio_r  <= prio_s;
            win_b_r <= win_b_s;
            wr_r    <= wr_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            w_en_r  <= w_en_s;
            ack_a_r <= ack_a_s;
            ack_b_r <= ack_b_s;
            busy_r  <= busy_s;
        end
    end

    assign ack_a     = ack_a_r;
    assign ack_b     = ack_b_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign rf_w_en   = w_en_r;
    assign rf_w_addr = addr_r;
    assign rf_r_addr = addr_r;
    assign rf_w_data = wdata_r;

    regfile_arbiter_checker u_checker (
        .clk     (clk),
        .reset   (reset),
        .ack_a   (ack_a_r),
        .ack_b   (ack_b_r),
        .busy    (busy_r),
        .rf_w_en (w_en_r)
    );

endmodule

// Protocol properties of the arbiter outputs.
module regfile_arbiter_checker (
    input logic clk,
    input logic reset,
    input logic ack_a,
    input logic ack_b,
    input logic busy,
    input logic rf_w_en
);

    a_ack_exclusive: assert property (@(posedge clk) disable iff (reset) !(ack_a && ack_b));
    a_wen_busy:      assert property (@(posedge clk) disable iff (reset) rf_w_en |-> busy);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file model.
module tb_regfile_arbiter;

    logic       clk, reset;
    logic       req_a, wr_a, req_b, wr_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b, busy, rf_w_en;
    logic [7:0] rdata, rf_w_data, rf_r_data;
    logic [1:0] rf_w_addr, rf_r_addr;
    logic [7:0] mem [4];
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       ra; logic wa; logic [1:0] aa; logic [7:0] da;
        logic       rb; logic wb; logic [1:0] ab; logic [7:0] db;
        logic       exp_b;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    regfile_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .busy(busy),
        .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_r_addr(rf_r_addr),
        .rf_w_data(rf_w_data), .rf_r_data(rf_r_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (rf_w_en) mem[rf_w_addr] <= rf_w_data;
    end
    assign rf_r_data = mem[rf_r_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " ack_a"}, 32'(ack_a), 32'd0);
        chk({tag, " ack_b"}, 32'(ack_b), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " rf_w_en"}, 32'(rf_w_en), 32'd0);
        chk({tag, " rf_w_addr"}, 32'(rf_w_addr), 32'd0);
        chk({tag, " rf_r_addr"}, 32'(rf_r_addr), 32'd0);
        chk({tag, " rf_w_data"}, 32'(rf_w_data), 32'd0);
        chk({tag, " rdata"}, 32'(rdata), 32'd0);
    endtask

    // Called at a negedge while the DUT is IDLE; returns at the negedge after ACK.
    task automatic run_vec(input vec_t v, input int idx);
        logic       ewr;
        logic [1:0] eaddr;
        logic [7:0] edata;
        string      t;
        t     = $sformatf("v%0d", idx);
        ewr   = v.exp_b ? v.wb : v.wa;
        eaddr = v.exp_b ? v.ab : v.aa;
        edata = v.exp_b ? v.db : v.da;
        req_a = v.ra; wr_a = v.wa; addr_a = v.aa; wdata_a = v.da;
        req_b = v.rb; wr_b = v.wb; addr_b = v.ab; wdata_b = v.db;
        @(negedge clk);
        chk({t, " access busy"}, 32'(busy), 32'd1);
        chk({t, " access w_en"}, 32'(rf_w_en), 32'(ewr));
        chk({t, " access w_addr"}, 32'(rf_w_addr), 32'(eaddr));
        chk({t, " access r_addr"}, 32'(rf_r_addr), 32'(eaddr));
        if (ewr) chk({t, " access w_data"}, 32'(rf_w_data), 32'(edata));
        chk({t, " access no ack"}, 32'({ack_a, ack_b}), 32'd0);
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        chk({t, " ack_a"}, 32'(ack_a), 32'(!v.exp_b));
        chk({t, " ack_b"}, 32'(ack_b), 32'(v.exp_b));
        chk({t, " rdata"}, 32'(rdata), 32'(v.exp_rd));
        chk({t, " ack w_en"}, 32'(rf_w_en), 32'd0);
        chk({t, " ack busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({t, " idle acks"}, 32'({ack_a, ack_b}), 32'd0);
        chk({t, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        //            ra    wa    aa    da      rb    wb    ab    db      winB  rdata
        vecs[0]  = '{1'b1, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h5A};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h22, 1'b1, 8'h5A};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h22, 1'b0, 8'h5A};
        vecs[4]  = '{1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h22, 1'b1, 8'h5A};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h22, 1'b0, 8'h5A};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h80, 1'b1, 8'h5A};
        vecs[7]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h80};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h11};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h22};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 8'h07, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h22};

        reset = 1'b1;
        req_a = 1'b0; wr_a = 1'b0; addr_a = 2'd0; wdata_a = 8'h00;
        req_b = 1'b0; wr_b = 1'b0; addr_b = 2'd0; wdata_b = 8'h00;
        #1;
        all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset lands in ACCESS of a write of 8'h7F over 8'h07 at address 1.
        req_a = 1'b1; wr_a = 1'b1; addr_a = 2'd1; wdata_a = 8'h7F;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 all_zero("rst_access");
        @(negedge clk);
        @(negedge clk);
        chk("rst_access no ack", 32'({ack_a, ack_b}), 32'd0);
        chk("rst_access mem1", 32'(mem[1]), 32'h07);
        req_a = 1'b0;
        reset = 1'b0;
        // After reset A has priority again and reads the unchanged value.
        run_vec('{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h07}, 11);

        // Reset lands in ACK of a read by B.
        req_b = 1'b1; wr_b = 1'b0; addr_b = 2'd0;
        @(negedge clk);
        req_b = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_ack ack_b", 32'(ack_b), 32'd1);
        chk("rst_ack rdata", 32'(rdata), 32'h11);
        reset = 1'b1;
        #1 all_zero("rst_ack");
        @(negedge clk);
        reset = 1'b0;

        chk("mem0", 32'(mem[0]), 32'h11);
        chk("mem1", 32'(mem[1]), 32'h07);
        chk("mem2", 32'(mem[2]), 32'h5A);
        chk("mem3", 32'(mem[3]), 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
